// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory access controller: FSM state encoding,
// the default read-wait limit and the timeout counter width.
package mem_access_pkg;

    // Two-bit state encoding, values fixed so waveforms decode the same everywhere.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } stateType;

    // Default read-wait cycle limit (legal range 2..255).
    localparam int DEFAULT_TIMEOUT = 16;

    // Eight bits covers every legal TIMEOUT value.
    localparam int TIMEOUT_CTR_WIDTH = 8;

    // The controller is busy whenever it is not waiting for a request.
    function automatic logic isBusy(input stateType s);
        return (s != IDLE);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Bundle of CPU request/response and RAM strobe signals for mem_access_ctrl.
// The master modport is the environment (CPU and RAM); the slave modport is
// the controller itself.
interface mem_access_ctrl_if #(
    parameter int width  = 8,
    parameter int length = 8
);
    // CPU request side
    logic              reqValid;
    logic              reqWrite;
    logic [length-1:0] reqAddr;
    logic [width-1:0]  reqData;

    // CPU response side
    logic              busy;
    logic              respValid;
    logic [width-1:0]  respData;
    logic              respError;

    // RAM side
    logic              ramWriteEnable;
    logic              ramReadEnable;
    logic [length-1:0] ramAddr;
    logic [length-1:0] ramReadAddr;
    logic [width-1:0]  ramWriteData;
    logic              ramDataReady;
    logic [width-1:0]  ramReadData;

    modport master (
        output reqValid, reqWrite, reqAddr, reqData,
        output ramDataReady, ramReadData,
        input  busy, respValid, respData, respError,
        input  ramWriteEnable, ramReadEnable, ramAddr, ramReadAddr, ramWriteData
    );

    modport slave (
        input  reqValid, reqWrite, reqAddr, reqData,
        input  ramDataReady, ramReadData,
        output busy, respValid, respData, respError,
        output ramWriteEnable, ramReadEnable, ramAddr, ramReadAddr, ramWriteData
    );

endinterface

// File: rtl/mem_access_ctrl_timeout_ctr.sv
// Read-wait cycle counter. Counts from 0 while enabled and clears as soon as
// enable drops, so every READ phase starts from 0. expired is high during the
// cycle in which the count would reach TIMEOUT on the next edge.
module mem_timeout_ctr
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic clr,
    input  logic enable,
    output logic expired
);

    logic [TIMEOUT_CTR_WIDTH-1:0] countReg;
    logic [TIMEOUT_CTR_WIDTH-1:0] countNext;

    // Next count: advance while enabled, otherwise restart at 0.
    always_comb begin
        countNext = '0;
        if (enable) begin
            countNext = countReg + 1'b1;
        end
    end

    // Count register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!clr) begin
            countReg <= '0;
        end else begin
            countReg <= countNext;
        end
    end

    // Last allowed wait cycle: count TIMEOUT-1 now, TIMEOUT after this edge.
    assign expired = enable && (countReg == TIMEOUT_CTR_WIDTH'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access controller: accepts one CPU load/store at a time in IDLE,
// drives a one-cycle RAM write strobe or a held read strobe, and reports
// completion with a one-cycle respValid pulse.
// Optional feature: define MEM_TIMEOUT_EN to bound the read wait to TIMEOUT
// cycles and report respError on expiry; otherwise READ waits forever.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int width   = 8,
    parameter int length  = 8,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic             clk,
    input  logic             clr,
    mem_access_ctrl_if.slave bus
);

    // Reject out-of-range read-wait limits at elaboration.
    if (TIMEOUT < 2 || TIMEOUT > 255) begin : gTimeoutRange
        $error("mem_access_ctrl: TIMEOUT must be within 2..255");
    end

    stateType          stateReg;
    stateType          stateNext;
    logic [length-1:0] addrReg;
    logic [length-1:0] addrNext;
    logic [width-1:0]  dataReg;
    logic [width-1:0]  dataNext;
    logic [width-1:0]  respDataReg;
    logic [width-1:0]  respDataNext;
    logic              ramWriteStrobe;
    logic              ramReadStrobe;
    logic              respPulse;

`ifdef MEM_TIMEOUT_EN
    logic              timeoutHit;
    logic              respErrReg;
    logic              respErrNext;

    // Read-wait counter, only enabled while the RAM read is outstanding.
    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) timeoutCtr (
        .clk     (clk),
        .clr     (clr),
        .enable  (stateReg == READ),
        .expired (timeoutHit)
    );
`endif

    // State, latched request and response registers; reset aborts any access.
    always_ff @(posedge clk) begin
        if (!clr) begin
            stateReg    <= IDLE;
            addrReg     <= '0;
            dataReg     <= '0;
            respDataReg <= '0;
`ifdef MEM_TIMEOUT_EN
            respErrReg  <= 1'b0;
`endif
        end else begin
            stateReg    <= stateNext;
            addrReg     <= addrNext;
            dataReg     <= dataNext;
            respDataReg <= respDataNext;
`ifdef MEM_TIMEOUT_EN
            respErrReg  <= respErrNext;
`endif
        end
    end

    // Next-state and strobe decode; registers hold unless a state updates them.
    always_comb begin
        stateNext      = stateReg;
        addrNext       = addrReg;
        dataNext       = dataReg;
        respDataNext   = respDataReg;
        ramWriteStrobe = 1'b0;
        ramReadStrobe  = 1'b0;
        respPulse      = 1'b0;
`ifdef MEM_TIMEOUT_EN
        respErrNext    = respErrReg;
`endif

        case (stateReg)
            IDLE: begin
                // Requests are only looked at here, so anything arriving
                // while busy is simply dropped.
                if (bus.reqValid) begin
                    addrNext  = bus.reqAddr;
                    dataNext  = bus.reqData;
`ifdef MEM_TIMEOUT_EN
                    respErrNext = 1'b0;
`endif
                    stateNext = bus.reqWrite ? WRITE : READ;
                end
            end

            WRITE: begin
                ramWriteStrobe = 1'b1;
                stateNext      = DONE;
            end

            READ: begin
                ramReadStrobe = 1'b1;
                // Data arriving on the final allowed cycle beats the timeout.
                if (bus.ramDataReady) begin
                    respDataNext = bus.ramReadData;
`ifdef MEM_TIMEOUT_EN
                    respErrNext  = 1'b0;
`endif
                    stateNext    = DONE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (timeoutHit) begin
                    respDataNext = '0;
                    respErrNext  = 1'b1;
                    stateNext    = DONE;
                end
`endif
            end

            DONE: begin
                respPulse = 1'b1;
                stateNext = IDLE;
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign bus.busy           = isBusy(stateReg);
    assign bus.respValid      = respPulse;
    assign bus.respData       = respDataReg;
    assign bus.ramWriteEnable = ramWriteStrobe;
    assign bus.ramReadEnable  = ramReadStrobe;
    assign bus.ramAddr        = addrReg;
    assign bus.ramReadAddr    = addrReg;
    assign bus.ramWriteData   = dataReg;

`ifdef MEM_TIMEOUT_EN
    assign bus.respError = respPulse & respErrReg;
`else
    assign bus.respError = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized self-checking bench for mem_access_ctrl. A behavioural RAM sits
// on the bus; a transaction-level reference (expected memory image, latency
// formula, last load result) predicts every response.
`timescale 1ns/1ps
module tb_mem_access_ctrl;
    import mem_access_pkg::*;

`ifdef MEM_TIMEOUT_EN
    localparam int TB_TIMEOUT = 4;
    localparam int MAX_DELAY  = TB_TIMEOUT + 2;
`else
    localparam int TB_TIMEOUT = DEFAULT_TIMEOUT;
    localparam int MAX_DELAY  = 6;
`endif

    logic clk;
    logic clr;

    mem_access_ctrl_if #(.width(8), .length(8)) bus ();

    mem_access_ctrl #(
        .width   (8),
        .length  (8),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errCount   = 0;
    int checkCount = 0;

    // Behavioural RAM contents and the reference's own expected image.
    logic [7:0] ramMem [256];
    logic [7:0] refMem [256];

    // RAM model state and observations.
    int         readDelay   = 0;
    bit         neverReady  = 0;
    int         waitCnt     = 0;
    int         writeCount  = 0;
    int         readCycles  = 0;
    bit         overlapSeen = 0;
    logic [7:0] lastWrAddr  = 0;
    logic [7:0] lastWrData  = 0;
    logic [7:0] lastRdAddr  = 0;

    // Reference: respData value expected to be held.
    logic [7:0] lastResp = 0;
    int         txnNum   = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance to the next negedge, then let the RAM model react to the
    // strobes of the current cycle and set its response for the next edge.
    task automatic nextCycle();
        @(negedge clk);
        if (bus.ramWriteEnable && bus.ramReadEnable) overlapSeen = 1;
        if (bus.ramWriteEnable) begin
            ramMem[bus.ramAddr] = bus.ramWriteData;
            writeCount++;
            lastWrAddr = bus.ramAddr;
            lastWrData = bus.ramWriteData;
        end
        if (bus.ramReadEnable) begin
            readCycles++;
            lastRdAddr = bus.ramReadAddr;
            if (!neverReady && waitCnt == readDelay) begin
                bus.ramDataReady = 1'b1;
                bus.ramReadData  = ramMem[bus.ramReadAddr];
            end else begin
                bus.ramDataReady = 1'b0;
                bus.ramReadData  = 8'($urandom);
                waitCnt++;
            end
        end else begin
            bus.ramDataReady = 1'b0;
            bus.ramReadData  = 8'($urandom);
            waitCnt          = 0;
        end
    endtask

    // One complete access from IDLE back to IDLE, checked against the reference.
    task automatic runOp(input bit wr, input logic [7:0] addr, input logic [7:0] data, input int delay);
        int         lat;
        int         expLat;
        bit         expErr;
        logic [7:0] expData;

        readDelay   = delay;
        writeCount  = 0;
        readCycles  = 0;
        overlapSeen = 0;
        bus.reqValid = 1'b1;
        bus.reqWrite = wr;
        bus.reqAddr  = addr;
        bus.reqData  = data;
        nextCycle();
        // Scramble request lines after acceptance: the latched copy must be used.
        bus.reqValid = 1'b0;
        bus.reqWrite = 1'($urandom);
        bus.reqAddr  = 8'($urandom);
        bus.reqData  = 8'($urandom);
        checkVal("busyAfterAccept", 32'(bus.busy), 32'd1);

        lat = 1;
        while (!bus.respValid && lat < 200) begin
            nextCycle();
            lat++;
        end

        // Reference prediction from the request and the RAM delay.
        expErr = 0;
        if (wr) begin
            expLat  = 2;
            refMem[addr] = data;
            expData = lastResp;
        end else begin
`ifdef MEM_TIMEOUT_EN
            expErr = neverReady || (delay > TB_TIMEOUT - 1);
`endif
            if (expErr) begin
                expLat  = 1 + TB_TIMEOUT;
                expData = 8'h00;
            end else begin
                expLat  = 2 + delay;
                expData = refMem[addr];
            end
            lastResp = expData;
        end

        checkVal("latency", 32'(lat), 32'(expLat));
        checkVal("respData", 32'(bus.respData), 32'(expData));
        checkVal("respError", 32'(bus.respError), 32'(expErr));
        if (wr) begin
            checkVal("wrAddr", 32'(lastWrAddr), 32'(addr));
            checkVal("wrData", 32'(lastWrData), 32'(data));
            checkVal("readsOnStore", 32'(readCycles), 32'd0);
        end else begin
            checkVal("rdAddr", 32'(lastRdAddr), 32'(addr));
        end
        checkVal("strobeOverlap", 32'(overlapSeen), 32'd0);

        nextCycle();
        checkVal("idleBusy", 32'(bus.busy), 32'd0);
        checkVal("idleRespValid", 32'(bus.respValid), 32'd0);
        checkVal("writeCount", 32'(writeCount), wr ? 32'd1 : 32'd0);

        $display("txn %0d: %s addr=%02h data=%02h delay=%0d lat=%0d respData=%02h err=%0b",
                 txnNum, wr ? "store" : "load ", addr, data, delay, lat, bus.respData, bus.respError);
        txnNum++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ramMem[i] = 8'($urandom);
            refMem[i] = ramMem[i];
        end
        clr              = 1'b0;
        bus.reqValid     = 1'b0;
        bus.reqWrite     = 1'b0;
        bus.reqAddr      = 8'h00;
        bus.reqData      = 8'h00;
        bus.ramDataReady = 1'b0;
        bus.ramReadData  = 8'h00;

        // Reset state
        repeat (3) nextCycle();
        checkVal("rstBusy", 32'(bus.busy), 32'd0);
        checkVal("rstRespValid", 32'(bus.respValid), 32'd0);
        checkVal("rstRespData", 32'(bus.respData), 32'd0);
        checkVal("rstRespError", 32'(bus.respError), 32'd0);
        checkVal("rstWe", 32'(bus.ramWriteEnable), 32'd0);
        checkVal("rstRe", 32'(bus.ramReadEnable), 32'd0);
        checkVal("rstAddr", 32'(bus.ramAddr), 32'd0);
        checkVal("rstWrData", 32'(bus.ramWriteData), 32'd0);
        clr = 1'b1;
        nextCycle();

        // Directed store then load of the same word.
        runOp(1'b1, 8'h05, 8'h3C, 0);
        runOp(1'b0, 8'h05, 8'h00, 3);

        // reqValid held through a store: one access, re-accepted only from IDLE.
        writeCount   = 0;
        bus.reqValid = 1'b1;
        bus.reqWrite = 1'b1;
        bus.reqAddr  = 8'h20;
        bus.reqData  = 8'h5A;
        nextCycle();
        nextCycle();
        checkVal("holdRespValid", 32'(bus.respValid), 32'd1);
        nextCycle();
        checkVal("holdIdleBusy", 32'(bus.busy), 32'd0);
        checkVal("holdOneWrite", 32'(writeCount), 32'd1);
        nextCycle();
        checkVal("holdReaccept", 32'(bus.busy), 32'd1);
        checkVal("holdSecondWrite", 32'(writeCount), 32'd2);
        bus.reqValid = 1'b0;
        nextCycle();
        nextCycle();
        checkVal("holdDoneBusy", 32'(bus.busy), 32'd0);
        checkVal("holdTotalWrites", 32'(writeCount), 32'd2);
        refMem[8'h20] = 8'h5A;
        $display("txn %0d: held-request store addra=20 data=5A writes=%0d", txnNum, writeCount);
        txnNum++;

        // Reset in the second READ cycle aborts the load.
        readDelay    = 10;
        bus.reqValid = 1'b1;
        bus.reqWrite = 1'b0;
        bus.reqAddr  = 8'h05;
        nextCycle();
        bus.reqValid = 1'b0;
        nextCycle();
        clr = 1'b0;
        nextCycle();
        checkVal("abortBusy", 32'(bus.busy), 32'd0);
        checkVal("abortRe", 32'(bus.ramReadEnable), 32'd0);
        checkVal("abortRespValid", 32'(bus.respValid), 32'd0);
        clr = 1'b1;
        lastResp = 8'h00;
        begin
            bit pulseSeen = 0;
            for (int i = 0; i < 5; i++) begin
                nextCycle();
                if (bus.respValid) pulseSeen = 1;
            end
            checkVal("abortNoPulse", 32'(pulseSeen), 32'd0);
        end
        $display("txn %0d: load aborted by reset in READ", txnNum);
        txnNum++;

        // Never-ready RAM.
`ifdef MEM_TIMEOUT_EN
        neverReady = 1;
        runOp(1'b0, 8'h05, 8'h00, 0);
        neverReady = 0;
`else
        begin
            bit pulseSeen = 0;
            bit busyDrop  = 0;
            neverReady   = 1;
            bus.reqValid = 1'b1;
            bus.reqWrite = 1'b0;
            bus.reqAddr  = 8'h05;
            nextCycle();
            bus.reqValid = 1'b0;
            for (int i = 0; i < 100; i++) begin
                if (!bus.busy) busyDrop = 1;
                if (bus.respValid) pulseSeen = 1;
                nextCycle();
            end
            checkVal("hangBusyHeld", 32'(busyDrop), 32'd0);
            checkVal("hangNoPulse", 32'(pulseSeen), 32'd0);
            clr = 1'b0;
            nextCycle();
            clr        = 1'b1;
            neverReady = 0;
            lastResp   = 8'h00;
            nextCycle();
            $display("txn %0d: never-ready load held busy for 100 cycles", txnNum);
            txnNum++;
        end
`endif

        // Randomized traffic over a small address window so loads hit stores.
        for (int n = 0; n < 40; n++) begin
            runOp(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
                  8'($urandom), int'($urandom_range(0, MAX_DELAY)));
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
